chdr_stream_monitor: RTL and testbench

//  Synthesizable, passive CHDR/CVITA packet monitor. Taps NUM_STREAMS 64-bit AXI-Stream buses without driving tready.
//  Per stream it parses header/timestamp, accumulates payload stats (count/sum/xor/min/max) and checks length and seqnum.

---
 rtl/chdr_stream_monitor_pkg.sv | 49 ++++
 rtl/chdr_stream_monitor_if.sv | 12 +
 rtl/chdr_stream_monitor_lane.sv | 140 ++++++++++++++
 rtl/chdr_stream_monitor.sv | 54 +++++
 tb/tb_chdr_stream_monitor.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/chdr_stream_monitor_pkg.sv
// Shared types for the CHDR/CVITA stream monitor: header layout, lane FSM states,
// readback field map and the payload statistics record.
package chdr_mon_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    PKT_DATA = 2'd0,
    PKT_FC   = 2'd1,
    PKT_CMD  = 2'd2,
    PKT_RESP = 2'd3
  } cvita_pkt_type_t;

  typedef struct packed {
    cvita_pkt_type_t pkt_type;
    logic            has_time;
    logic            eob;
    logic [11:0]     seqnum;
    logic [15:0]     length;
    logic [31:0]     sid;
  } chdr_hdr_t;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_TIME = 2'd1,
    S_BODY = 2'd2
  } lane_state_t;

  localparam logic [2:0] RB_HDR   = 3'd0;
  localparam logic [2:0] RB_TS    = 3'd1;
  localparam logic [2:0] RB_COUNT = 3'd2;
  localparam logic [2:0] RB_SUM   = 3'd3;
  localparam logic [2:0] RB_MIN   = 3'd4;
  localparam logic [2:0] RB_MAX   = 3'd5;
  localparam logic [2:0] RB_XOR   = 3'd6;
  localparam logic [2:0] RB_CNTS  = 3'd7;

  typedef struct packed {
    logic [31:0]       count;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] min;
    logic [DATA_W-1:0] max;
    logic [DATA_W-1:0] xsum;
  } chdr_stats_t;

  localparam chdr_stats_t STATS_RST = '{count: 32'd0, sum: 64'd0, min: {64{1'b1}},
                                        max: 64'd0, xsum: 64'd0};

endpackage

// File: rtl/chdr_stream_monitor_if.sv
// Tapped AXI-Stream bundle for NUM_STREAMS lanes; the monitor only ever listens.
interface chdr_stream_monitor_if #(
  parameter int NUM_STREAMS = 1
);
  logic [64*NUM_STREAMS-1:0] tdata;
  logic [NUM_STREAMS-1:0]    tlast;
  logic [NUM_STREAMS-1:0]    tvalid;
  logic [NUM_STREAMS-1:0]    tready;

  modport master (output tdata, tlast, tvalid, tready);
  modport slave  (input  tdata, tlast, tvalid, tready);
endinterface

// File: rtl/chdr_stream_monitor_lane.sv
// One monitored lane: packet parse FSM, payload statistics, length/seqnum checks,
// finalized result registers and saturating error counters.
module chdr_stream_monitor_lane
  import chdr_mon_pkg::*;
#(
  parameter bit CHECK_SEQNUM = 1'b1,
  parameter int ERR_CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tlast,
  input  logic [2:0]        rb_addr,
  output logic [63:0]       rb_word,
  output logic              pkt_done,
  output logic              len_err,
  output logic              seq_err
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  lane_state_t       state_p0, state_nxt;
  chdr_hdr_t         hdr_p0, hdr_nxt, res_hdr_p1;
  logic [DATA_W-1:0] ts_p0, ts_nxt, res_ts_p1;
  chdr_stats_t       st_p0, st_nxt, res_st_p1;
  logic [31:0]       beats_p0, beats_nxt;
  logic [11:0]       last_seq;
  logic              seq_valid;
  logic [31:0]       pkt_cnt;
  logic [ERR_CNT_W-1:0] len_cnt, seq_cnt;
  logic [34:0]       bytes, len35;
  logic              len_ok, seq_bad, fin;
  logic [32+2*ERR_CNT_W-1:0] cnt_word;

  // Stage 0: fold the current beat into the in-flight packet
  always_comb begin
    hdr_nxt   = hdr_p0;
    ts_nxt    = ts_p0;
    st_nxt    = st_p0;
    beats_nxt = beats_p0 + 32'd1;
    state_nxt = state_p0;
    case (state_p0)
      S_HDR: begin
        hdr_nxt   = chdr_hdr_t'(tdata);
        ts_nxt    = '0;
        st_nxt    = STATS_RST;
        beats_nxt = 32'd1;
        state_nxt = tlast ? S_HDR : (hdr_nxt.has_time ? S_TIME : S_BODY);
      end
      S_TIME: begin
        ts_nxt    = tdata;
        state_nxt = tlast ? S_HDR : S_BODY;
      end
      default: begin
        st_nxt.count = st_p0.count + 32'd1;
        st_nxt.sum   = st_p0.sum + tdata;
        st_nxt.xsum  = st_p0.xsum ^ tdata;
        st_nxt.min   = (tdata < st_p0.min) ? tdata : st_p0.min;
        st_nxt.max   = (tdata > st_p0.max) ? tdata : st_p0.max;
        state_nxt    = tlast ? S_HDR : S_BODY;
      end
    endcase
  end

  // Length may cover whole words or end 4 bytes into the last word
  assign bytes   = {beats_nxt, 3'b000};
  assign len35   = {19'd0, hdr_nxt.length};
  assign len_ok  = (len35 == bytes) || (len35 == bytes - 35'd4);
  assign seq_bad = CHECK_SEQNUM && seq_valid && (hdr_nxt.seqnum != last_seq + 12'd1);
  assign fin     = beat && tlast;

  always_ff @(posedge clk) begin
    if (beat) begin
      hdr_p0   <= hdr_nxt;
      ts_p0    <= ts_nxt;
      st_p0    <= st_nxt;
      beats_p0 <= beats_nxt;
    end
  end

  // Stage 1: finalized results, pulses and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0   <= S_HDR;
      res_hdr_p1 <= '0;
      res_ts_p1  <= '0;
      res_st_p1  <= '0;
      last_seq   <= '0;
      seq_valid  <= 1'b0;
      pkt_cnt    <= '0;
      len_cnt    <= '0;
      seq_cnt    <= '0;
      pkt_done   <= 1'b0;
      len_err    <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      pkt_done <= fin;
      len_err  <= fin && !len_ok;
      seq_err  <= fin && seq_bad;
      if (beat) state_p0 <= state_nxt;
      if (fin) begin
        res_hdr_p1 <= hdr_nxt;
        res_ts_p1  <= ts_nxt;
        res_st_p1  <= st_nxt;
        last_seq   <= hdr_nxt.seqnum;
        seq_valid  <= 1'b1;
        pkt_cnt    <= pkt_cnt + 32'd1;
        if (!len_ok) len_cnt <= sat_inc(len_cnt);
        if (seq_bad) seq_cnt <= sat_inc(seq_cnt);
      end
      if (clear) begin
        pkt_cnt   <= '0;
        len_cnt   <= '0;
        seq_cnt   <= '0;
        seq_valid <= 1'b0;
      end
    end
  end

  assign cnt_word = {pkt_cnt, seq_cnt, len_cnt};

  always_comb begin
    rb_word = '0;
    case (rb_addr)
      RB_HDR:   rb_word = res_hdr_p1;
      RB_TS:    rb_word = res_ts_p1;
      RB_COUNT: rb_word = {32'd0, res_st_p1.count};
      RB_SUM:   rb_word = res_st_p1.sum;
      RB_MIN:   rb_word = res_st_p1.min;
      RB_MAX:   rb_word = res_st_p1.max;
      RB_XOR:   rb_word = res_st_p1.xsum;
      default:  rb_word = 64'(cnt_word);
    endcase
  end

endmodule

// File: rtl/chdr_stream_monitor.sv
// Passive CHDR packet monitor: one lane per tapped stream plus a registered
// readback mux selecting stream and field.
module chdr_stream_monitor
  import chdr_mon_pkg::*;
#(
  parameter int NUM_STREAMS  = 1,
  parameter bit CHECK_SEQNUM = 1'b1,
  parameter int ERR_CNT_W    = 16,
  localparam int SEL_W       = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  chdr_stream_monitor_if.slave   tap,
  input  logic [SEL_W-1:0]       i_rb_sel,
  input  logic [2:0]             i_rb_addr,
  output logic [63:0]            o_rb_data,
  output logic [NUM_STREAMS-1:0] o_pkt_done,
  output logic [NUM_STREAMS-1:0] o_len_err,
  output logic [NUM_STREAMS-1:0] o_seq_err
);

  // Padded to the full select range so unused selects read back as zero
  logic [63:0] rb_word [2**SEL_W];

  for (genvar s = 0; s < 2**SEL_W; s++) begin : g_lane
    if (s < NUM_STREAMS) begin : g_used
      chdr_stream_monitor_lane #(
        .CHECK_SEQNUM (CHECK_SEQNUM),
        .ERR_CNT_W    (ERR_CNT_W)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .clear    (i_clear),
        .beat     (tap.tvalid[s] & tap.tready[s]),
        .tdata    (tap.tdata[64*s +: 64]),
        .tlast    (tap.tlast[s]),
        .rb_addr  (i_rb_addr),
        .rb_word  (rb_word[s]),
        .pkt_done (o_pkt_done[s]),
        .len_err  (o_len_err[s]),
        .seq_err  (o_seq_err[s])
      );
    end else begin : g_pad
      assign rb_word[s] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) o_rb_data <= '0;
    else       o_rb_data <= rb_word[i_rb_sel];
  end

endmodule

// File: tb/tb_chdr_stream_monitor.sv
// Directed bench for chdr_stream_monitor: a 4-lane seqnum-checking instance and a
// 3-lane instance without seqnum checking share one tapped bus.
module tb_chdr_stream_monitor;
  import chdr_mon_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [255:0] tdata  = '0;
  logic [3:0]   tlast  = '0;
  logic [3:0]   tvalid = '0;
  logic [3:0]   tready = '0;
  logic [1:0]   rb_sel  = '0;
  logic [2:0]   rb_addr = '0;
  logic [63:0]  rb_a, rb_b;
  logic [3:0]   done_a, lerr_a, serr_a;
  logic [2:0]   done_b, lerr_b, serr_b;
  logic [63:0]  va, vb;

  int total = 0;
  int bad   = 0;

  chdr_stream_monitor_if #(.NUM_STREAMS(4)) bus ();
  assign bus.tdata  = tdata;
  assign bus.tlast  = tlast;
  assign bus.tvalid = tvalid;
  assign bus.tready = tready;

  chdr_stream_monitor #(.NUM_STREAMS(4), .CHECK_SEQNUM(1'b1), .ERR_CNT_W(16)) dut_a (
    .clk(clk), .reset(rst), .i_clear(clr), .tap(bus.slave),
    .i_rb_sel(rb_sel), .i_rb_addr(rb_addr), .o_rb_data(rb_a),
    .o_pkt_done(done_a), .o_len_err(lerr_a), .o_seq_err(serr_a));

  chdr_stream_monitor #(.NUM_STREAMS(3), .CHECK_SEQNUM(1'b0), .ERR_CNT_W(16)) dut_b (
    .clk(clk), .reset(rst), .i_clear(clr), .tap(bus.slave),
    .i_rb_sel(rb_sel), .i_rb_addr(rb_addr), .o_rb_data(rb_b),
    .o_pkt_done(done_b), .o_len_err(lerr_b), .o_seq_err(serr_b));

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkhdr(input logic ht, input logic [11:0] seq, input logic [15:0] len);
    return {2'b00, ht, 1'b0, seq, len, 32'h0000_0000};
  endfunction

  task automatic beat(input int s, input logic [63:0] d, input logic last);
    tdata[64*s +: 64] = d;
    tlast[s]  = last;
    tvalid[s] = 1'b1;
    tready[s] = 1'b1;
    @(posedge clk); #1;
    tvalid[s] = 1'b0;
    tready[s] = 1'b0;
    tlast[s]  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [2:0] addr);
    rb_sel  = sel;
    rb_addr = addr;
    @(posedge clk); #1;
    va = rb_a;
    vb = rb_b;
  endtask

  // Multi-lane scenario data
  logic        ht   [4];
  logic [11:0] sq   [4];
  int          np   [4];
  logic [63:0] tsv  [4];
  logic [63:0] pay  [4][8];

  task automatic drive_lane(input int s);
    logic [63:0] w [10];
    int nb, k, lenb;
    nb = 1 + int'(ht[s]) + np[s];
    lenb = (s == 2) ? 8*nb - 4 : 8*nb;
    w[0] = mkhdr(ht[s], sq[s], 16'(lenb));
    k = 1;
    if (ht[s]) begin w[1] = tsv[s]; k = 2; end
    for (int i = 0; i < np[s]; i++) w[k+i] = pay[s][i];
    for (int i = 0; i < nb; i++) begin
      int st;
      st = $urandom_range(0, 3);
      for (int j = 0; j < st; j++) begin
        tdata[64*s +: 64] = {$urandom, $urandom};
        tvalid[s] = 1'b1;
        tready[s] = 1'b0;
        tlast[s]  = (j % 2 == 0);
        @(posedge clk); #1;
      end
      tdata[64*s +: 64] = w[i];
      tvalid[s] = 1'b1;
      tready[s] = 1'b1;
      tlast[s]  = (i == nb - 1);
      @(posedge clk); #1;
    end
    tvalid[s] = 1'b0;
    tready[s] = 1'b0;
    tlast[s]  = 1'b0;
  endtask

  initial begin
    logic [63:0] e_sum, e_xor, e_min, e_max;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_rb", rb_a, 64'd0);
    chk_val("rst_done", {60'd0, done_a}, 64'd0);
    rst = 1'b0;
    rd(2'd0, RB_CNTS);
    chk_val("rst_cnts", va, 64'd0);

    // Header-only packet
    beat(0, mkhdr(1'b0, 12'd0, 16'd8), 1'b1);
    chk_val("t1_done_a", {63'd0, done_a[0]}, 64'd1);
    chk_val("t1_done_b", {63'd0, done_b[0]}, 64'd1);
    chk_val("t1_lerr", {63'd0, lerr_a[0]}, 64'd0);
    @(posedge clk); #1;
    chk_val("t1_pulse_len", {63'd0, done_a[0]}, 64'd0);
    rd(2'd0, RB_COUNT); chk_val("t1_count", va, 64'd0);
    rd(2'd0, RB_MIN);   chk_val("t1_min", va, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(2'd0, RB_MAX);   chk_val("t1_max", va, 64'd0);
    rd(2'd0, RB_CNTS);  chk_val("t1_cnts", va, 64'h0000_0001_0000_0000);

    // Timed packet with 4 payload words
    beat(0, mkhdr(1'b1, 12'd1, 16'd48), 1'b0);
    beat(0, 64'h1234, 1'b0);
    beat(0, 64'd1, 1'b0);
    beat(0, 64'd2, 1'b0);
    beat(0, 64'd3, 1'b0);
    beat(0, 64'd4, 1'b1);
    chk_val("t2_done", {63'd0, done_a[0]}, 64'd1);
    chk_val("t2_errs", {62'd0, lerr_a[0], serr_a[0]}, 64'd0);
    rd(2'd0, RB_HDR);   chk_val("t2_hdr", va, mkhdr(1'b1, 12'd1, 16'd48));
    rd(2'd0, RB_TS);    chk_val("t2_ts", va, 64'h1234);
    rd(2'd0, RB_COUNT); chk_val("t2_count", va, 64'd4);
    rd(2'd0, RB_SUM);   chk_val("t2_sum", va, 64'd10);
    rd(2'd0, RB_MIN);   chk_val("t2_min", va, 64'd1);
    rd(2'd0, RB_MAX);   chk_val("t2_max", va, 64'd4);
    rd(2'd0, RB_XOR);   chk_val("t2_xor", va, 64'd4);

    // Length checking
    beat(0, mkhdr(1'b0, 12'd2, 16'd40), 1'b0);
    beat(0, 64'd7, 1'b0);
    beat(0, 64'd8, 1'b0);
    beat(0, 64'd9, 1'b1);
    chk_val("t3_lerr_a", {63'd0, lerr_a[0]}, 64'd1);
    chk_val("t3_lerr_b", {63'd0, lerr_b[0]}, 64'd1);
    rd(2'd0, RB_CNTS); chk_val("t3_cnts", va, 64'h0000_0003_0000_0001);
    beat(0, mkhdr(1'b0, 12'd3, 16'd28), 1'b0);
    beat(0, 64'd7, 1'b0);
    beat(0, 64'd8, 1'b0);
    beat(0, 64'd9, 1'b1);
    chk_val("t3_ok_lerr", {63'd0, lerr_a[0]}, 64'd0);
    rd(2'd0, RB_CNTS); chk_val("t3_cnts2", va, 64'h0000_0004_0000_0001);

    // Seqnum wrap and discontinuity, starting from a cleared baseline
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    beat(0, mkhdr(1'b0, 12'd4094, 16'd8), 1'b1);
    chk_val("t4_first", {63'd0, serr_a[0]}, 64'd0);
    beat(0, mkhdr(1'b0, 12'd4095, 16'd8), 1'b1);
    chk_val("t4_4095", {63'd0, serr_a[0]}, 64'd0);
    beat(0, mkhdr(1'b0, 12'd0, 16'd8), 1'b1);
    chk_val("t4_wrap", {63'd0, serr_a[0]}, 64'd0);
    beat(0, mkhdr(1'b0, 12'd2, 16'd8), 1'b1);
    chk_val("t4_gap_a", {63'd0, serr_a[0]}, 64'd1);
    chk_val("t4_gap_b", {63'd0, serr_b[0]}, 64'd0);
    rd(2'd0, RB_CNTS);
    chk_val("t4_cnts_a", va, 64'h0000_0004_0001_0000);
    chk_val("t4_cnts_b", vb, 64'h0000_0004_0000_0000);

    // Clear coincident with a finalizing (bad-length) packet
    clr = 1'b1;
    beat(0, mkhdr(1'b0, 12'd3, 16'd16), 1'b1);
    clr = 1'b0;
    chk_val("t6_done", {63'd0, done_a[0]}, 64'd1);
    chk_val("t6_lerr", {63'd0, lerr_a[0]}, 64'd1);
    rd(2'd0, RB_CNTS); chk_val("t6_cnts", va, 64'd0);
    rd(2'd0, RB_HDR);  chk_val("t6_hdr", va, mkhdr(1'b0, 12'd3, 16'd16));
    beat(0, mkhdr(1'b0, 12'd7, 16'd8), 1'b1);
    chk_val("t6_noseq", {63'd0, serr_a[0]}, 64'd0);
    rd(2'd0, RB_CNTS); chk_val("t6_cnts2", va, 64'h0000_0001_0000_0000);

    // Four interleaved lanes with random stalls
    for (int s = 0; s < 4; s++) begin
      ht[s]  = (s % 2 == 1);
      sq[s]  = (s == 0) ? 12'd8 : 12'($urandom_range(0, 4095));
      np[s]  = 2 + s;
      tsv[s] = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) pay[s][i] = {$urandom, $urandom};
    end
    fork
      drive_lane(0);
      drive_lane(1);
      drive_lane(2);
      drive_lane(3);
    join
    for (int s = 0; s < 4; s++) begin
      e_sum = '0; e_xor = '0; e_min = '1; e_max = '0;
      for (int i = 0; i < np[s]; i++) begin
        e_sum += pay[s][i];
        e_xor ^= pay[s][i];
        if (pay[s][i] < e_min) e_min = pay[s][i];
        if (pay[s][i] > e_max) e_max = pay[s][i];
      end
      rd(2'(s), RB_TS);    chk_val($sformatf("t5_ts%0d", s), va, ht[s] ? tsv[s] : 64'd0);
      rd(2'(s), RB_COUNT); chk_val($sformatf("t5_cnt%0d", s), va, 64'(np[s]));
      rd(2'(s), RB_SUM);   chk_val($sformatf("t5_sum%0d", s), va, e_sum);
      rd(2'(s), RB_MIN);   chk_val($sformatf("t5_min%0d", s), va, e_min);
      rd(2'(s), RB_MAX);   chk_val($sformatf("t5_max%0d", s), va, e_max);
      rd(2'(s), RB_XOR);   chk_val($sformatf("t5_xor%0d", s), va, e_xor);
      if (s < 3) chk_val($sformatf("t5_b_xor%0d", s), vb, e_xor);
      else       chk_val("t5_b_oor", vb, 64'd0);
      rd(2'(s), RB_CNTS);
      chk_val($sformatf("t5_cnts%0d", s), va, (s == 0) ? 64'h0000_0002_0000_0000
                                                       : 64'h0000_0001_0000_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
